boot_hex_dumper: RTL and testbench

- Transmit-side counterpart of the boot hex loader: reads a block of words from memory and emits it as ASCII hex text, one word per line, for a UART transmitter.
- Each word becomes 8 uppercase hex characters, MSB nibble first, followed by CR and LF.
- Output text re-parses to the same data/address sequence through the boot hex loader.
- Sits between the on-chip memory read port and the UART TX character interface.

---
 rtl/boot_hex_dumper_if.sv | 36 +++
 rtl/boot_hex_dumper.sv | 166 ++++++++++++++++
 tb/tb_boot_hex_dumper.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_hex_dumper_if.sv
// Bus bundle for the boot hex dumper: the memory read port plus the
// character stream going to the UART transmitter.
interface boot_hex_dumper_if #(
   parameter int address_width = 32,
   parameter int data_width    = 32,
   parameter int char_width    = 8
);

   logic                     mem_rd_req;
   logic [address_width-1:0] mem_address;
   logic [data_width-1:0]    mem_rd_data;
   logic                     out_valid;
   logic [char_width-1:0]    out_char;
   logic                     out_ready;

   // The dumper issues reads and produces characters
   modport master (
      output mem_rd_req,
      output mem_address,
      input  mem_rd_data,
      output out_valid,
      output out_char,
      input  out_ready
   );

   // Memory and UART side: answers reads and accepts characters
   modport slave (
      input  mem_rd_req,
      input  mem_address,
      output mem_rd_data,
      input  out_valid,
      input  out_char,
      output out_ready
   );

endinterface

// File: rtl/boot_hex_dumper.sv
// Boot hex dumper: reads a block of words from memory and emits each word
// as uppercase ASCII hex (MSB nibble first) followed by CR LF, so the text
// can be fed back through the boot hex loader.
module boot_hex_dumper #(
   parameter int address_width = 32,
   parameter int data_width    = 32,
   parameter int char_width    = 8,
   parameter int count_width   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [address_width-1:0] start_address,
   input  logic [count_width-1:0]   num_words,
   boot_hex_dumper_if.master        bus,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      SEND,
      CR,
      LF
   } state_t;

   localparam int NIBBLES = data_width / 4;
   localparam int NIB_W   = $clog2(NIBBLES + 1);
   localparam logic [NIB_W-1:0]         LAST_NIB  = NIB_W'(NIBBLES - 1);
   localparam logic [address_width-1:0] ADDR_STEP = address_width'(data_width / 8);
   localparam logic [count_width-1:0]   ONE_WORD  = count_width'(1);

   state_t                   state;
   state_t                   next_state;
   logic [address_width-1:0] cur_address;
   logic [count_width-1:0]   remaining;
   logic [data_width-1:0]    shift_reg;
   logic [NIB_W-1:0]         nib_cnt;

   logic                     rd_req;
   logic [address_width-1:0] rd_address;
   logic                     char_valid;
   logic [char_width-1:0]    char_out;

   // Nibble to uppercase ASCII hex digit
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end
      return 8'h37 + {4'h0, nib};
   endfunction

   // State register; reset drops straight back to IDLE and abandons any dump
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and output decode; outputs depend on state only so they
   // stay stable while the consumer stalls a character
   always_comb begin
      next_state = state;
      rd_req     = 1'b0;
      rd_address = '0;
      char_valid = 1'b0;
      char_out   = '0;
      case (state)
         IDLE: begin
            if (start && (num_words != '0)) begin
               next_state = READ;
            end
         end
         READ: begin
            rd_req     = 1'b1;
            rd_address = cur_address;
            next_state = WAIT;
         end
         WAIT: begin
            next_state = SEND;
         end
         SEND: begin
            char_valid = 1'b1;
            char_out   = char_width'(hex_ascii(shift_reg[data_width-1 -: 4]));
            if (bus.out_ready && (nib_cnt == LAST_NIB)) begin
               next_state = CR;
            end
         end
         CR: begin
            char_valid = 1'b1;
            char_out   = char_width'(8'h0D);
            if (bus.out_ready) begin
               next_state = LF;
            end
         end
         LF: begin
            char_valid = 1'b1;
            char_out   = char_width'(8'h0A);
            if (bus.out_ready) begin
               next_state = (remaining == ONE_WORD) ? IDLE : READ;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath: address/count bookkeeping, word shifting and the done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_address <= '0;
         remaining   <= '0;
         shift_reg   <= '0;
         nib_cnt     <= '0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (num_words == '0) begin
                     done <= 1'b1;
                  end else begin
                     cur_address <= start_address;
                     remaining   <= num_words;
                  end
               end
            end
            WAIT: begin
               shift_reg <= bus.mem_rd_data;
               nib_cnt   <= '0;
            end
            SEND: begin
               if (bus.out_ready) begin
                  shift_reg <= shift_reg << 4;
                  nib_cnt   <= nib_cnt + NIB_W'(1);
               end
            end
            LF: begin
               if (bus.out_ready) begin
                  if (remaining == ONE_WORD) begin
                     done <= 1'b1;
                  end else begin
                     cur_address <= cur_address + ADDR_STEP;
                     remaining   <= remaining - ONE_WORD;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.mem_rd_req  = rd_req;
   assign bus.mem_address = rd_address;
   assign bus.out_valid   = char_valid;
   assign bus.out_char    = char_out;
   assign busy            = (state != IDLE);

endmodule

// File: tb/tb_boot_hex_dumper.sv
// Self-checking bench for boot_hex_dumper: table-driven dumps checked by a
// scoreboard of expected read addresses and characters, plus hand-written
// sequences for stall, zero count and reset corner cases.
module tb_boot_hex_dumper;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int CW = 8;
   localparam int NW = 16;

   typedef struct packed {
      logic [31:0]       addr;
      logic [15:0]       n;
      logic [2:0][31:0]  words;
      logic [2:0][31:0]  exp_addr;
      logic [239:0]      exp_text;
      logic [1:0]        ready_mode;
      logic              mid_start;
      logic              timing;
      logic              stall;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] start_address;
   logic [NW-1:0] num_words;
   logic          busy;
   logic          done;

   boot_hex_dumper_if #(.address_width(AW), .data_width(DW), .char_width(CW)) bus ();

   boot_hex_dumper #(
      .address_width(AW),
      .data_width(DW),
      .char_width(CW),
      .count_width(NW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .start_address(start_address),
      .num_words(num_words),
      .bus(bus.master),
      .busy(busy),
      .done(done)
   );

   logic [31:0] addr_q[$];
   logic [7:0]  char_q[$];
   logic [31:0] mem [logic [31:0]];
   vec_t        vecs[4];

   int   n_compared = 0;
   int   n_mismatched = 0;
   int   cycle = 0;
   int   read_count = 0;
   int   char_count = 0;
   int   valid_count = 0;
   int   done_count = 0;
   int   first_read_cycle = 0;
   int   first_char_cycle = 0;
   int   last_char_cycle = 0;
   int   done_cycle = 0;
   int   ready_mode = 0;
   logic busy_at_done = 1'b0;
   logic prev_stall = 1'b0;
   logic [7:0] prev_char = 8'h00;

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used for latency checks
   always @(posedge clk) cycle++;

   // Memory model answering each read one cycle later
   always @(posedge clk) begin
      if (bus.mem_rd_req) begin
         bus.mem_rd_data <= mem.exists(bus.mem_address) ? mem[bus.mem_address] : 32'hBAD0BAD0;
      end
   end

   // Consumer ready pattern: always ready, random, or stalled
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = 1'($urandom_range(0, 1));
         default: bus.out_ready = 1'b0;
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input int act, input int exp);
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Output monitor: pops scoreboard entries on reads and accepted characters
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid_held", 64'(bus.out_valid), 64'd1);
            check("stall_char_held", 64'(bus.out_char), 64'(prev_char));
         end
         if (bus.mem_rd_req) begin
            if (read_count == 0) first_read_cycle = cycle;
            read_count++;
            if (addr_q.size() == 0) fail_now("unexpected_read", int'(bus.mem_address), -1);
            else check("read_address", 64'(bus.mem_address), 64'(addr_q.pop_front()));
         end
         if (bus.out_valid) valid_count++;
         if (bus.out_valid && bus.out_ready) begin
            if (char_count == 0) first_char_cycle = cycle;
            last_char_cycle = cycle;
            char_count++;
            if (char_q.size() == 0) fail_now("unexpected_char", int'(bus.out_char), -1);
            else check("out_char", 64'(bus.out_char), 64'(char_q.pop_front()));
         end
         if (done) begin
            done_count++;
            done_cycle = cycle;
            busy_at_done = busy;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_char = bus.out_char;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle_negedge();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_counters();
      read_count = 0;
      char_count = 0;
      valid_count = 0;
      done_count = 0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_mem_rd_req"}, 64'(bus.mem_rd_req), 64'd0);
      check({tag, "_mem_address"}, 64'(bus.mem_address), 64'd0);
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_out_char"}, 64'(bus.out_char), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
   endtask

   task automatic load_vec(input vec_t v);
      int len;
      len = int'(v.n) * 10;
      for (int i = 0; i < int'(v.n); i++) begin
         mem[v.exp_addr[i]] = v.words[i];
         addr_q.push_back(v.exp_addr[i]);
      end
      for (int k = 0; k < len; k++) char_q.push_back(v.exp_text[(len - 1 - k) * 8 +: 8]);
   endtask

   task automatic applyStimulus(input vec_t v);
      int  c0;
      int  budget;
      int  stall_left;
      bit  pulsed;
      bit  stalled;
      settle_negedge();
      clear_counters();
      load_vec(v);
      ready_mode = int'(v.ready_mode);
      tick();
      start = 1'b1;
      start_address = v.addr;
      num_words = v.n;
      c0 = cycle;
      tick();
      start = 1'b0;
      budget = 0;
      pulsed = 1'b0;
      stalled = 1'b0;
      stall_left = 0;
      while (done_count == 0 && budget < 3000) begin
         settle_negedge();
         budget++;
         if (v.mid_start) begin
            if (start) start = 1'b0;
            else if (!pulsed && char_count >= 5) begin
               start = 1'b1;
               start_address = 32'h500;
               num_words = 16'd1;
               pulsed = 1'b1;
            end
         end
         if (v.stall) begin
            if (stall_left > 0) begin
               check("stall_on_digit_3", 64'(bus.out_char), 64'h33);
               stall_left--;
               if (stall_left == 0) ready_mode = 1;
            end else if (!stalled && bus.out_valid && bus.out_char == 8'h32) begin
               ready_mode = 2;
               stalled = 1'b1;
               stall_left = 5;
               settle_negedge();
            end
         end
      end
      start = 1'b0;
      if (done_count == 0) fail_now("done_timeout", budget, 0);
      ready_mode = 0;
      checkOutput(v, c0);
   endtask

   task automatic checkOutput(input vec_t v, input int c0);
      repeat (5) tick();
      check("done_pulses", 64'(done_count), 64'd1);
      check("busy_at_done", 64'(busy_at_done), 64'd0);
      check("reads_left", 64'(addr_q.size()), 64'd0);
      check("chars_left", 64'(char_q.size()), 64'd0);
      check("read_count", 64'(read_count), 64'(v.n));
      check("char_count", 64'(char_count), 64'(int'(v.n) * 10));
      if (v.timing) begin
         check("first_read_cycle", 64'(first_read_cycle - c0), 64'd1);
         check("first_char_cycle", 64'(first_char_cycle - c0), 64'd3);
         check("last_char_cycle", 64'(last_char_cycle - c0), 64'd12);
         check("done_cycle", 64'(done_cycle - c0), 64'd13);
      end
   endtask

   initial begin
      vec_t bp;
      vec_t rv;
      vec_t pre;
      int   c0;
      int   budget;
      int   done_before;

      for (int i = 0; i < 4; i++) vecs[i] = '0;
      vecs[0].addr = 32'h100;  vecs[0].n = 16'd1;
      vecs[0].words[0] = 32'h1234ABCD; vecs[0].exp_addr[0] = 32'h100;
      vecs[0].exp_text = 240'("1234ABCD\015\012");
      vecs[0].timing = 1'b1;

      vecs[1].addr = 32'h0;    vecs[1].n = 16'd3;
      vecs[1].words[0] = 32'h00000000; vecs[1].exp_addr[0] = 32'h0;
      vecs[1].words[1] = 32'hFFFFFFFF; vecs[1].exp_addr[1] = 32'h4;
      vecs[1].words[2] = 32'hDEADBEEF; vecs[1].exp_addr[2] = 32'h8;
      vecs[1].exp_text = 240'("00000000\015\012FFFFFFFF\015\012DEADBEEF\015\012");
      vecs[1].mid_start = 1'b1;

      vecs[2].addr = 32'hFFFFFFFC; vecs[2].n = 16'd2;
      vecs[2].words[0] = 32'h89ABCDEF; vecs[2].exp_addr[0] = 32'hFFFFFFFC;
      vecs[2].words[1] = 32'h01234567; vecs[2].exp_addr[1] = 32'h00000000;
      vecs[2].exp_text = 240'("89ABCDEF\015\01201234567\015\012");

      vecs[3].addr = 32'h40;   vecs[3].n = 16'd1;
      vecs[3].words[0] = 32'h5A6B7C8D; vecs[3].exp_addr[0] = 32'h40;
      vecs[3].exp_text = 240'("5A6B7C8D\015\012");
      vecs[3].ready_mode = 2'd1;

      reset = 1'b1;
      start = 1'b0;
      start_address = '0;
      num_words = '0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check_outputs_zero("reset");
      reset = 1'b0;
      repeat (2) tick();

      $display("[TB] table-driven dumps");
      for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

      $display("[TB] backpressure stall on digit 3");
      bp = vecs[0];
      bp.timing = 1'b0;
      bp.stall = 1'b1;
      applyStimulus(bp);

      $display("[TB] zero word count");
      settle_negedge();
      clear_counters();
      tick();
      start = 1'b1;
      start_address = 32'h300;
      num_words = 16'd0;
      c0 = cycle;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("zero_done_pulses", 64'(done_count), 64'd1);
      check("zero_done_cycle", 64'(done_cycle - c0), 64'd1);
      check("zero_reads", 64'(read_count), 64'd0);
      check("zero_valid", 64'(valid_count), 64'd0);

      $display("[TB] reset mid-dump");
      pre = '0;
      pre.addr = 32'h200; pre.n = 16'd1;
      pre.words[0] = 32'hCAFEF00D; pre.exp_addr[0] = 32'h200;
      pre.exp_text = 240'("CAFEF00D\015\012");
      settle_negedge();
      clear_counters();
      load_vec(pre);
      tick();
      start = 1'b1;
      start_address = pre.addr;
      num_words = pre.n;
      tick();
      start = 1'b0;
      budget = 0;
      while (char_count < 5 && budget < 100) begin
         settle_negedge();
         budget++;
      end
      if (char_count < 5) fail_now("reset_wait_timeout", char_count, 5);
      done_before = done_count;
      reset = 1'b1;
      #1;
      check_outputs_zero("midreset");
      addr_q.delete();
      char_q.delete();
      repeat (2) tick();
      reset = 1'b0;
      repeat (5) tick();
      check("no_done_after_reset", 64'(done_count), 64'(done_before));
      check("idle_after_reset", 64'(busy), 64'd0);

      rv = '0;
      rv.addr = 32'h20; rv.n = 16'd1;
      rv.words[0] = 32'h0F1E2D3C; rv.exp_addr[0] = 32'h20;
      rv.exp_text = 240'("0F1E2D3C\015\012");
      rv.timing = 1'b1;
      applyStimulus(rv);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   // Last-resort guard so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
